// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter with a small byte FIFO in front of
// the shifter. Bytes written while o_TX_Ready is high are queued. The FSM
// pops the head byte whenever it is idle and the queue is non-empty.
//
// Ports
//   i_Clock       system clock, all logic on its rising edge
//   i_Reset       synchronous active-high reset
//   i_TX_DV       write strobe for i_TX_Byte
//   i_TX_Byte     byte to queue for transmission
//   o_TX_Ready    FIFO not full; writes accepted only while high
//   o_TX_Active   a frame is on the line (START, DATA or STOP)
//   o_TX_Serial   UART line, idle high
//   o_TX_Done     one-cycle pulse in the first IDLE cycle after a frame
//   o_FIFO_Count  bytes stored and not yet popped
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high; pops the head byte when the FIFO is non-empty
// START | start bit (0) for CLKS_PER_BIT cycles
// DATA  | data bits, LSB first, bit_idx_q selects the current bit
// STOP  | stop bit (1); leaving it raises o_TX_Done for one cycle
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_TX_DV,
  input  logic [7:0]                   i_TX_Byte,
  output logic                         o_TX_Ready,
  output logic                         o_TX_Active,
  output logic                         o_TX_Serial,
  output logic                         o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]  o_FIFO_Count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH    = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          serial_q;
  logic          active_q;
  logic          done_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic [PW:0]   count_d;

  logic push;
  logic pop;

  // Ready depends only on registered count, so a write arriving in the same
  // cycle as a pop from a full FIFO is still refused.
  assign o_TX_Ready = (count_q < DEPTH);
  assign push       = i_TX_DV && o_TX_Ready && !i_Reset;
  assign pop        = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_TX_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_TX_Active  = active_q;
  assign o_TX_Serial  = serial_q;
  assign o_TX_Done    = done_q;
  assign o_FIFO_Count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. A bench-side UART receiver decodes
// the serial line into a byte queue with frame start cycles; each test task
// compares DUT behaviour against hand-computed values.
module tb_uart_tx_fifo;

  localparam int CPB   = 217;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, active, serial, done;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rx_ferr = 0;

  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         rx_bit = 0;
  logic [7:0] rx_sh = 8'h00;
  int         rx_t0 = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_TX_DV     (dv),
    .i_TX_Byte   (din),
    .o_TX_Ready  (ready),
    .o_TX_Active (active),
    .o_TX_Serial (serial),
    .o_TX_Done   (done),
    .o_FIFO_Count(count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Receiver: samples the middle of each bit, position 0 is the first low cycle.
  always @(negedge clk) begin
    if (rst) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (serial === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
        rx_bit  <= 0;
        rx_t0   <= cyc;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == rx_bit * CPB + CPB / 2) begin
        rx_bit <= rx_bit + 1;
        if (rx_bit == 0) begin
          if (serial !== 1'b0) rx_busy <= 1'b0;
        end else if (rx_bit <= 8) begin
          rx_sh <= {serial, rx_sh[7:1]};
        end else begin
          if (serial === 1'b1) begin
            rx_q.push_back(rx_sh);
            rx_t.push_back(rx_t0);
          end else begin
            rx_ferr <= rx_ferr + 1;
          end
          rx_busy <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    dv  = 1'b1;
    din = b;
    tick();
    dv  = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      if (!active && count == 3'd0 && !rx_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dv  = 1'b1;
    din = 8'hEE;
    repeat (3) tick();
    checks++; if (serial !== 1'b1) begin errors++; $display("FAIL rst_serial: got %b expected 1", serial); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", active); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    rst = 1'b0;
    dv  = 1'b0;
    tick();
    tick();
    checks++; if (count !== 3'd0 || serial !== 1'b1) begin
      errors++; $display("FAIL rst_dv_ignored: got count=%0d serial=%b expected count=0 serial=1", count, serial);
    end
  endtask

  task automatic test_single_byte();
    int         base_q, base_d, bad;
    logic [9:0] frame;
    base_q = rx_q.size();
    base_d = done_cnt;
    frame  = {1'b1, 8'h37, 1'b0};
    write_byte(8'h37);
    checks++; if (count !== 3'd1 || serial !== 1'b1) begin
      errors++; $display("FAIL single_n1: got count=%0d serial=%b expected count=1 serial=1", count, serial);
    end
    tick();
    checks++; if (serial !== 1'b0 || active !== 1'b1 || count !== 3'd0) begin
      errors++; $display("FAIL single_n2: got serial=%b active=%b count=%0d expected 0 1 0", serial, active, count);
    end
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (serial !== frame[k]) bad++;
        tick();
      end
      checks++; if (bad != 0) begin
        errors++; $display("FAIL single_bit%0d: got %0d wrong cycles expected 0 (level %b)", k, bad, frame[k]);
      end
    end
    checks++; if (done !== 1'b1 || serial !== 1'b1 || active !== 1'b0) begin
      errors++; $display("FAIL single_done: got done=%b serial=%b active=%b expected 1 1 0", done, serial, active);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", done); end
    checks++; if (rx_q.size() != base_q + 1 || rx_q[base_q] !== 8'h37) begin
      errors++; $display("FAIL single_rx: got %0d bytes expected 1 byte 37", rx_q.size() - base_q);
    end
    checks++; if (done_cnt - base_d != 1) begin
      errors++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt - base_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4];
    int base_q, base_d, peak;
    bit ok;
    b = '{8'h4D, 8'hA5, 8'h00, 8'hFF};
    base_q = rx_q.size();
    base_d = done_cnt;
    peak   = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, ready); end
      write_byte(b[i]);
      if (int'(count) > peak) peak = int'(count);
    end
    checks++; if (peak != 3 && peak != 4) begin errors++; $display("FAIL b2b_peak: got %0d expected 3 or 4", peak); end
    drain(12000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy expected idle"); end
    checks++; if (rx_q.size() != base_q + 4) begin
      errors++; $display("FAIL b2b_nbytes: got %0d expected 4", rx_q.size() - base_q);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rx_q[base_q+i] !== b[i]) begin
          errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[base_q+i], b[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++; if (rx_t[base_q+i] - rx_t[base_q+i-1] != FRAME) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, rx_t[base_q+i] - rx_t[base_q+i-1], FRAME);
        end
      end
    end
    checks++; if (done_cnt - base_d != 4) begin
      errors++; $display("FAIL b2b_done_cnt: got %0d expected 4", done_cnt - base_d);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] b [5];
    int base_q, base_d, n;
    bit ok;
    b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    base_q = rx_q.size();
    base_d = done_cnt;
    write_byte(b[0]);
    tick();
    checks++; if (count !== 3'd0 || active !== 1'b1) begin
      errors++; $display("FAIL full_started: got count=%0d active=%b expected 0 1", count, active);
    end
    for (int i = 1; i < 5; i++) write_byte(b[i]);
    checks++; if (count !== 3'd4 || ready !== 1'b0) begin
      errors++; $display("FAIL full_count: got count=%0d ready=%b expected 4 0", count, ready);
    end
    write_byte(8'h99);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject: got %0d expected 4", count); end
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_wait_done: got %b expected 1", done); end
    // Write on the pop cycle of a full FIFO: pop happens, write is dropped.
    dv  = 1'b1;
    din = 8'h99;
    tick();
    dv  = 1'b0;
    checks++; if (count !== 3'd3 || ready !== 1'b1) begin
      errors++; $display("FAIL full_pop_write: got count=%0d ready=%b expected 3 1", count, ready);
    end
    drain(12000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got busy expected idle"); end
    checks++; if (rx_q.size() != base_q + 5) begin
      errors++; $display("FAIL full_nbytes: got %0d expected 5", rx_q.size() - base_q);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (rx_q[base_q+i] !== b[i]) begin
          errors++; $display("FAIL full_byte%0d: got %h expected %h", i, rx_q[base_q+i], b[i]);
        end
      end
    end
    checks++; if (done_cnt - base_d != 5) begin
      errors++; $display("FAIL full_done_cnt: got %0d expected 5", done_cnt - base_d);
    end
  endtask

  task automatic test_write_on_pop();
    int base_q, base_d;
    bit ok;
    base_q = rx_q.size();
    base_d = done_cnt;
    write_byte(8'h5A);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL pop_first: got %0d expected 1", count); end
    write_byte(8'hC6);
    checks++; if (count !== 3'd1 || active !== 1'b1) begin
      errors++; $display("FAIL pop_same_cycle: got count=%0d active=%b expected 1 1", count, active);
    end
    drain(6000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pop_timeout: got busy expected idle"); end
    checks++; if (rx_q.size() != base_q + 2 || rx_q[base_q] !== 8'h5A || rx_q[base_q+1] !== 8'hC6) begin
      errors++; $display("FAIL pop_bytes: got %0d bytes expected 5A C6", rx_q.size() - base_q);
    end else begin
      checks++; if (rx_t[base_q+1] - rx_t[base_q] != FRAME) begin
        errors++; $display("FAIL pop_gap: got %0d expected %0d", rx_t[base_q+1] - rx_t[base_q], FRAME);
      end
    end
    checks++; if (done_cnt - base_d != 2) begin
      errors++; $display("FAIL pop_done_cnt: got %0d expected 2", done_cnt - base_d);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base_q, base_d, bad;
    bit ok;
    write_byte(8'h3C);
    write_byte(8'h11);
    write_byte(8'h22);
    checks++; if (count !== 3'd2 || serial !== 1'b0) begin
      errors++; $display("FAIL rmf_queued: got count=%0d serial=%b expected 2 0", count, serial);
    end
    // Frame began one cycle ago; move to the middle of data bit 3.
    repeat (4 * CPB + CPB / 2 - 1) tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rmf_active: got %b expected 1", active); end
    base_d = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (serial !== 1'b1 || count !== 3'd0 || active !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL rmf_after: got serial=%b count=%0d active=%b ready=%b expected 1 0 0 1",
                         serial, count, active, ready);
    end
    bad = 0;
    for (int c = 0; c < 3 * CPB; c++) begin
      if (serial !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmf_line_high: got %0d low cycles expected 0", bad); end
    checks++; if (done_cnt != base_d) begin
      errors++; $display("FAIL rmf_no_done: got %0d pulses expected 0", done_cnt - base_d);
    end
    base_q = rx_q.size();
    base_d = done_cnt;
    write_byte(8'h12);
    drain(6000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmf_timeout: got busy expected idle"); end
    checks++; if (rx_q.size() != base_q + 1 || rx_q[base_q] !== 8'h12) begin
      errors++; $display("FAIL rmf_next: got %0d bytes expected 1 byte 12", rx_q.size() - base_q);
    end
    checks++; if (done_cnt - base_d != 1) begin
      errors++; $display("FAIL rmf_done_cnt: got %0d expected 1", done_cnt - base_d);
    end
  endtask

  task automatic test_stream();
    int base_q, base_d, idx, n;
    bit ok;
    base_q = rx_q.size();
    base_d = done_cnt;
    idx = 0;
    n   = 0;
    while (idx < 9 && n < 30000) begin
      if (ready === 1'b1) begin
        write_byte(8'(idx + 1));
        idx++;
      end else begin
        tick();
      end
      n++;
    end
    checks++; if (idx != 9) begin errors++; $display("FAIL stream_accept: got %0d expected 9", idx); end
    drain(15000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_timeout: got busy expected idle"); end
    checks++; if (rx_q.size() != base_q + 9) begin
      errors++; $display("FAIL stream_nbytes: got %0d expected 9", rx_q.size() - base_q);
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++; if (rx_q[base_q+i] !== 8'(i + 1)) begin
          errors++; $display("FAIL stream_byte%0d: got %h expected %h", i, rx_q[base_q+i], 8'(i + 1));
        end
      end
    end
    checks++; if (done_cnt - base_d != 9) begin
      errors++; $display("FAIL stream_done_cnt: got %0d expected 9", done_cnt - base_d);
    end
    checks++; if (rx_ferr != 0) begin errors++; $display("FAIL framing: got %0d errors expected 0", rx_ferr); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fifo_full();
    test_write_on_pop();
    test_reset_mid_frame();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per serial bit (25 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte entries buffered ahead of the shifter; power of two, >= 2.
REQ-003 SHALL have port i_Clock  input  1  meaning single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Reset  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port i_TX_DV  input  1  meaning write strobe for i_TX_Byte, sampled each cycle.
REQ-006 SHALL have port i_TX_Byte  input  8  meaning byte to transmit.
REQ-007 SHALL have port o_TX_Ready  output  1  meaning FIFO not full; a write is accepted only when this is high.
REQ-008 SHALL have port o_TX_Active  output  1  meaning a frame is on the line (START, DATA or STOP state).
REQ-009 SHALL have port o_TX_Serial  output  1  meaning UART line, idle high.
REQ-010 SHALL have port o_TX_Done  output  1  meaning one-cycle pulse after each completed frame.
REQ-011 SHALL have port o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  meaning number of stored, not yet popped bytes.

Function
REQ-012 SHALL send 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-013 SHALL implement states IDLE, START, DATA, STOP; bit-clock counter sized $clog2(CLKS_PER_BIT), bit index 3 bits.
REQ-014 SHALL, in IDLE with o_FIFO_Count > 0, pop the head byte into the shift register and enter START on the next edge.
REQ-015 SHALL advance START->DATA, DATA bit 7->STOP and STOP->IDLE when the counter reaches CLKS_PER_BIT-1; counter clears on each bit change.
REQ-016 SHALL assert o_TX_Done for exactly the first IDLE cycle after STOP; low otherwise.
REQ-017 SHALL give latency: byte written in cycle N into an empty FIFO while IDLE -> count 1 at N+1 -> o_TX_Serial low from N+2.
REQ-018 SHALL make back-to-back frames 10*CLKS_PER_BIT+1 cycles apart (one IDLE cycle, line high, between frames).
REQ-019 SHALL compute o_TX_Ready = (o_FIFO_Count < FIFO_DEPTH) from registered state only.
REQ-020 SHALL ignore a write while o_TX_Ready is low: no FIFO, count or pointer change, even if a pop occurs in the same cycle.
REQ-021 SHALL, on a simultaneous accepted write and pop, store and pop both; count unchanged.
REQ-022 SHALL wrap read/write pointers modulo FIFO_DEPTH with no data corruption.
REQ-023 SHALL not alter the byte in the shift register when the FIFO is written during a frame.
REQ-024 SHALL hold o_TX_Serial high in IDLE and o_TX_Active low in IDLE.

Reset
REQ-025 SHALL, on i_Reset high at a clock edge, set state IDLE, counters 0, pointers 0, o_FIFO_Count 0, o_TX_Serial 1, o_TX_Active 0, o_TX_Done 0, o_TX_Ready 1.
REQ-026 SHALL abort any frame in progress on reset mid-frame: line high the cycle after the reset edge; queued bytes discarded; no o_TX_Done.
REQ-027 SHALL ignore i_TX_DV in any cycle where i_Reset is high.

Verification
REQ-028 Single byte 0x37, CLKS_PER_BIT=217 -> line 0, then 1,1,1,0,1,1,0,0, then 1, each 217 cycles; o_TX_Done pulses once; a uart_rx loopback decodes 0x37.
REQ-029 Write 0x4D, 0xA5, 0x00, 0xFF in 4 consecutive cycles -> all accepted, count peaks at 3 or 4, four frames exactly 2171 cycles apart in order, four o_TX_Done pulses.
REQ-030 Fill FIFO during a frame (count 4), then write 0x99 -> o_TX_Ready low, 0x99 never transmitted, count stays 4.
REQ-031 Write on the exact IDLE-pop cycle with count 1 -> count remains 1, both bytes sent in order.
REQ-032 Assert i_Reset during DATA bit 3 with 2 bytes queued -> o_TX_Serial 1 next cycle, count 0, no o_TX_Done, next write 0x12 transmits cleanly.
REQ-033 Stream 9 bytes 0x01..0x09 throttled by o_TX_Ready -> pointers wrap twice, output sequence 0x01..0x09 exact.
